// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I core
package riscv_pkg;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_if.sv
// riscv_fetch_stage_if: instruction memory request/response bus
interface riscv_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/riscv_if_id_reg.sv
// riscv_if_id_reg: IF/ID pipeline register with load, stall and flush controls
module riscv_if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr
);
    logic        r_valid;
    logic [31:0] r_pc, r_pc4, r_instr;

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;

    // Flush beats stall; an unstalled cycle without a new word leaves a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
            r_instr <= NOP_INSTR;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!i_stall) begin
            r_valid <= i_load;
            r_instr <= i_load ? i_instr : NOP_INSTR;
            if (i_load) begin
                r_pc  <= i_pc;
                r_pc4 <= i_pc + 32'd4;
            end
        end
    end
endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC, single-outstanding fetch FSM, hold buffer and IF/ID register
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       pcSrc,
    input  logic [31:0]                target_pc,
    riscv_fetch_stage_if.master        imem,
    output logic                       if_id_valid,
    output logic [31:0]                if_id_pc,
    output logic [31:0]                if_id_pc4,
    output logic [31:0]                if_id_instr
);
    import riscv_pkg::*;

    fetch_state_e r_state, w_next;
    logic [31:0]  r_pc, r_req_pc, r_hold_instr, w_load_instr;
    logic         r_hold_valid, w_load;

    assign imem.req     = rst_n && r_state == REQ;
    assign imem.addr    = r_pc;
    assign w_load       = !flush && !stall &&
                          ((r_state == WAIT && imem.rvalid) || (r_state == HOLD && r_hold_valid));
    assign w_load_instr = r_state == HOLD ? r_hold_instr : imem.rdata;

    // Next state: a redirect drains any accepted request whose response is still due
    always_comb begin
        w_next = r_state;
        case (r_state)
            REQ:     w_next = imem.ready ? (flush ? DRAIN : WAIT) : REQ;
            WAIT:    w_next = flush ? (imem.rvalid ? REQ : DRAIN)
                                    : (imem.rvalid ? (stall ? HOLD : REQ) : WAIT);
            HOLD:    w_next = (flush || !stall) ? REQ : HOLD;
            DRAIN:   w_next = imem.rvalid ? REQ : DRAIN;
            default: w_next = REQ;
        endcase
    end

    // Fetch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= REQ;
        else        r_state <= w_next;
    end

    // PC, accepted-request PC and the hold buffer for words arriving under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_hold_valid <= 1'b0;
        end else begin
            if (flush) begin
                if (pcSrc) r_pc <= word_align(target_pc);
            end else if (w_load) begin
                r_pc <= r_req_pc + 32'd4;
            end
            if (r_state == REQ && imem.ready) r_req_pc <= r_pc;
            if (flush || (r_state == HOLD && !stall)) begin
                r_hold_valid <= 1'b0;
            end else if (r_state == WAIT && imem.rvalid && stall) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= imem.rdata;
            end
        end
    end

    riscv_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_stall (stall),
        .i_flush (flush),
        .i_pc    (r_req_pc),
        .i_instr (w_load_instr),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_pc4   (if_id_pc4),
        .o_instr (if_id_instr)
    );

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem.rvalid |-> (r_state == WAIT || r_state == DRAIN));
endmodule
